free_list: RTL and testbench
============================

Name: free_list

Overview:
- Bitmap physical-register free list for the R10K rename path.
- Hands up to N free PR tags per cycle to dispatch/rename.
- Reclaims PRs from the retire stage's free_mask.
- Keeps a shadow architectural free bitmap, updated only by retire, so a branch-mispredict recovery restores the speculative free list in one cycle.

Parameters:
- N, `N: superscalar width; number of allocation lanes.
- ARCH_COUNT, `ARCH_REG_SZ: architectural registers; PRs 0..ARCH_COUNT-1 are mapped at reset.
- PHYS_REGS, `PHYS_REG_SZ_R10K: physical register count.
- Derived localparam CW = $clog2(PHYS_REGS+1): free-count width.

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- alloc_req  in  N  lane i of dispatch wants a PR this cycle.
- alloc_tags  out  N x PHYS_TAG  tag offered to lane i: the i-th lowest-numbered free PR.
- alloc_valid  out  N  alloc_tags[i] is valid (free_count > i).
- free_count  out  CW  popcount of the speculative free bitmap.
- free_mask  in  PHYS_REGS  PRs released by retire this cycle (Told of committed lanes).
- arch_write_enables  in  N  retire commit lanes writing the arch map.
- arch_write_phys_regs  in  N x PHYS_TAG  PR committed per lane.
- bp_recover_en  in  1  mispredict recovery pulse from retire.

Behaviour:
- State: spec_free[PHYS_REGS-1:0] and arch_free[PHYS_REGS-1:0]; 1 = free.
- Reset:
  - Both bitmaps = 1 for PRs ARCH_COUNT..PHYS_REGS-1, 0 otherwise.
  - In the cycle after reset deasserts: free_count = PHYS_REGS-ARCH_COUNT, alloc_tags[i] = ARCH_COUNT+i, alloc_valid all 1 (if enough PRs).
  - Reset mid-operation discards all in-flight state identically; reset dominates bp_recover_en.
- Offer:
  - alloc_tags/alloc_valid/free_count are combinational from registered spec_free only.
  - There is no same-cycle bypass of free_mask.
  - Selection is an N-deep lowest-index-first priority chain: lane 0 takes the lowest free PR, lane 1 the next lowest, etc.
  - alloc_tags[i] = 0 when alloc_valid[i] = 0.
- Consume:
  - Lane i consumes iff alloc_req[i] && alloc_valid[i].
  - Non-contiguous requests are legal; the tag for lane i is fixed regardless of other lanes' requests.
  - Requests with alloc_valid[i] = 0 are ignored; dispatch must stall.
- Normal update:
  - spec_free_next = (spec_free & ~consumed) | free_mask_eff.
  - free_mask_eff = free_mask with bit 0 forced 0; PR0 is never freed.
  - A free appears in free_count/alloc_tags the cycle after it is presented (1-cycle latency).
  - Double-free of an already-free PR has no effect.
- Arch update (every cycle, independent of recovery):
  - arch_free_next = (arch_free | free_mask_eff) & ~committed.
  - committed = OR over lanes w with arch_write_enables[w] of onehot(arch_write_phys_regs[w]).
  - Tags >= PHYS_REGS are ignored.
- Recovery: if bp_recover_en, spec_free_next = arch_free_next, which includes this cycle's retire frees and commits. All allocations in the recovery cycle are discarded.
- Illegal and non-recoverable (bench assertion): the same PR is both freed and committed in one cycle.
- Invariant (bench check):
  - spec_free ⊆ arch_free | (PRs freed since last recovery).
  - free_count never exceeds PHYS_REGS-ARCH_COUNT+ (number of commits outstanding).
- free_count never underflows: at most free_count lanes can consume.

Decomposition:
- PHYS_TAG, `N, `ARCH_REG_SZ, `PHYS_REG_SZ_R10K already live in sys_defs.svh; no new typedefs are needed.
- Sub-module free_list_psel: parameterised N-output lowest-first priority selector over a PHYS_REGS bitmap, producing tags and valids.
  - Reusable by other bitmap allocators (RS, LSQ).
- Popcount is inline.

Test Plan (N=3, ARCH_COUNT=32, PHYS_REGS=64):
- Reset held 2 cycles, then released → free_count=32, alloc_tags={32,33,34}, alloc_valid=3'b111.
- alloc_req=3'b111 for one cycle → next cycle free_count=29, tags={35,36,37}; alloc_req=3'b101 → lanes 0,2 take 35,37, next tags={36,38,39}, count 27.
- Allocate PR 32, then free_mask bit 32 asserted → same cycle tags unchanged; next cycle lane0 tag=32, count +1. Also free_mask bit 0 → no change.
- Drain to free_count=1 (only PR 63 free), alloc_req=3'b111 → alloc_valid=3'b001, lane0 gets 63; next cycle free_count=0, alloc_valid=0, tags all 0.
- After reset, allocate 32..37, then one cycle with arch_write_enables=3'b001, arch_write_phys_regs[0]=32, free_mask bit 1, bp_recover_en=1, alloc_req=3'b111 → next cycle spec_free = {1, 33..63}, free_count=32, tags={1,33,34}.
- Mid-drain reset with alloc_req=3'b111 and free_mask nonzero in the same cycle → next cycle state identical to the first scenario.

Source files
------------

// File: rtl/free_list_pkg.sv
// Shared defaults for the R10K physical-register free list.
package free_list_pkg;

  localparam int FL_N          = 3;
  localparam int FL_ARCH_COUNT = 32;
  localparam int FL_PHYS_REGS  = 64;

endpackage

// File: rtl/free_list_psel.sv
// N-output lowest-index-first priority selector over a bitmap.
module free_list_psel #(
  parameter int N     = 3,
  parameter int WIDTH = 64,
  parameter int TAG_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]        bitmap,
  output logic [N-1:0][TAG_W-1:0] tags,
  output logic [N-1:0]            valid
);

  logic [WIDTH-1:0] remaining;

  // Each stage picks the lowest set bit left over by the previous stages.
  always_comb begin
    remaining = bitmap;
    tags      = '0;
    valid     = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = WIDTH - 1; j >= 0; j--) begin
        if (remaining[j]) begin
          valid[i] = 1'b1;
          tags[i]  = TAG_W'(j);
        end
      end
      if (valid[i]) remaining[tags[i]] = 1'b0;
    end
  end

endmodule

// File: rtl/free_list.sv
// Bitmap free list with a retire-maintained architectural shadow for one-cycle recovery.
module free_list
  import free_list_pkg::*;
#(
  parameter int N          = FL_N,
  parameter int ARCH_COUNT = FL_ARCH_COUNT,
  parameter int PHYS_REGS  = FL_PHYS_REGS,
  localparam int TAG_W     = $clog2(PHYS_REGS),
  localparam int CW        = $clog2(PHYS_REGS + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N-1:0]            alloc_req,
  output logic [N-1:0][TAG_W-1:0] alloc_tags,
  output logic [N-1:0]            alloc_valid,
  output logic [CW-1:0]           free_count,
  input  logic [PHYS_REGS-1:0]    free_mask,
  input  logic [N-1:0]            arch_write_enables,
  input  logic [N-1:0][TAG_W-1:0] arch_write_phys_regs,
  input  logic                    bp_recover_en
);

  localparam logic [PHYS_REGS-1:0] RESET_FREE = {PHYS_REGS{1'b1}} << ARCH_COUNT;

  logic [PHYS_REGS-1:0] spec_free, arch_free;
  logic [PHYS_REGS-1:0] spec_free_next, arch_free_next;
  logic [PHYS_REGS-1:0] free_mask_eff, consumed, committed;

  free_list_psel #(
    .N     (N),
    .WIDTH (PHYS_REGS),
    .TAG_W (TAG_W)
  ) u_psel (
    .bitmap (spec_free),
    .tags   (alloc_tags),
    .valid  (alloc_valid)
  );

  always_comb begin
    free_count = '0;
    for (int j = 0; j < PHYS_REGS; j++) free_count = free_count + CW'(spec_free[j]);
  end

  // PR0 is hard-wired as never freeable.
  assign free_mask_eff = {free_mask[PHYS_REGS-1:1], 1'b0};

  always_comb begin
    consumed = '0;
    for (int i = 0; i < N; i++) begin
      if (alloc_req[i] && alloc_valid[i]) consumed[alloc_tags[i]] = 1'b1;
    end
  end

  always_comb begin
    committed = '0;
    for (int w = 0; w < N; w++) begin
      if (arch_write_enables[w] && (int'(arch_write_phys_regs[w]) < PHYS_REGS))
        committed[arch_write_phys_regs[w]] = 1'b1;
    end
  end

  always_comb begin
    arch_free_next = (arch_free | free_mask_eff) & ~committed;
    spec_free_next = (spec_free & ~consumed) | free_mask_eff;
    if (bp_recover_en) spec_free_next = arch_free_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      spec_free <= RESET_FREE;
      arch_free <= RESET_FREE;
    end else begin
      spec_free <= spec_free_next;
      arch_free <= arch_free_next;
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Directed vector table plus randomized run against an array-based free-list model.
module tb_free_list;

  localparam int NL = 3;
  localparam logic [63:0] INIT_MAP = 64'hFFFF_FFFF_0000_0000;

  logic                clock = 1'b0;
  logic                reset;
  logic [NL-1:0]       alloc_req;
  logic [NL-1:0][5:0]  alloc_tags;
  logic [NL-1:0]       alloc_valid;
  logic [6:0]          free_count;
  logic [63:0]         free_mask;
  logic [NL-1:0]       arch_write_enables;
  logic [NL-1:0][5:0]  arch_write_phys_regs;
  logic                bp_recover_en;

  int total = 0;
  int bad   = 0;

  logic [63:0] m_spec, m_arch;

  free_list #(.N(NL), .ARCH_COUNT(32), .PHYS_REGS(64)) dut (
    .clock                (clock),
    .reset                (reset),
    .alloc_req            (alloc_req),
    .alloc_tags           (alloc_tags),
    .alloc_valid          (alloc_valid),
    .free_count           (free_count),
    .free_mask            (free_mask),
    .arch_write_enables   (arch_write_enables),
    .arch_write_phys_regs (arch_write_phys_regs),
    .bp_recover_en        (bp_recover_en)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic              rst;
    logic [2:0]        req;
    logic [63:0]       fm;
    logic [2:0]        awe;
    logic [2:0][5:0]   awr;
    logic              rec;
    int                exp_count;
    logic [2:0]        exp_valid;
    logic [2:0][5:0]   exp_tags;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_row(logic rst, logic [2:0] req, logic [63:0] fm, logic [2:0] awe,
                                  logic [2:0][5:0] awr, logic rec, int cnt, logic [2:0] v,
                                  int t0, int t1, int t2);
    vec_t r;
    r.rst = rst; r.req = req; r.fm = fm; r.awe = awe; r.awr = awr; r.rec = rec;
    r.exp_count = cnt; r.exp_valid = v;
    r.exp_tags[0] = 6'(t0); r.exp_tags[1] = 6'(t1); r.exp_tags[2] = 6'(t2);
    vecs.push_back(r);
  endfunction

  // Reference offer: scan the free set in ascending order, first NL hits go to lanes.
  function automatic void model_offer(output int cnt, output logic [2:0] v, output logic [2:0][5:0] t);
    int k = 0;
    cnt = 0; v = '0; t = '0;
    for (int p = 0; p < 64; p++) begin
      if (m_spec[p]) begin
        cnt++;
        if (k < NL) begin v[k] = 1'b1; t[k] = 6'(p); k++; end
      end
    end
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(string name);
    int cnt; logic [2:0] v; logic [2:0][5:0] t;
    model_offer(cnt, v, t);
    cmp({name, ".count"}, 32'(free_count), 32'(cnt));
    cmp({name, ".valid"}, 32'(alloc_valid), 32'(v));
    cmp({name, ".tags"}, 32'(alloc_tags), 32'(t));
  endtask

  task automatic do_cycle(logic rst, logic [2:0] req, logic [63:0] fm, logic [2:0] awe,
                          logic [2:0][5:0] awr, logic rec);
    int cnt; logic [2:0] v; logic [2:0][5:0] t;
    logic [63:0] cons, comm, fme, arch_n, spec_n;
    reset = rst; alloc_req = req; free_mask = fm; arch_write_enables = awe;
    arch_write_phys_regs = awr; bp_recover_en = rec;
    #1;
    check_model("offer");
    model_offer(cnt, v, t);
    cons = '0;
    for (int i = 0; i < NL; i++) if (req[i] && v[i]) cons[t[i]] = 1'b1;
    comm = '0;
    for (int w = 0; w < NL; w++) if (awe[w]) comm[awr[w]] = 1'b1;
    fme = fm; fme[0] = 1'b0;
    assert ((fme & comm) == 64'd0) else $error("stimulus frees and commits the same PR");
    arch_n = (m_arch | fme) & ~comm;
    spec_n = (m_spec & ~cons) | fme;
    if (rec) spec_n = arch_n;
    if (rst) begin spec_n = INIT_MAP; arch_n = INIT_MAP; end
    @(posedge clock);
    m_spec = spec_n; m_arch = arch_n;
    #1;
  endtask

  initial begin
    logic [2:0][5:0] z;
    logic [2:0][5:0] awr;
    logic [63:0] fm;
    logic [2:0] awe;
    z = '0;
    reset = 1'b1; alloc_req = '0; free_mask = '0; arch_write_enables = '0;
    arch_write_phys_regs = '0; bp_recover_en = 1'b0;
    @(posedge clock); #1;
    m_spec = INIT_MAP; m_arch = INIT_MAP;

    // Directed table: expected values are the outputs after each row's clock edge.
    add_row(1, 3'b000, 64'd0, 3'b000, z, 0, 32, 3'b111, 32, 33, 34);
    add_row(1, 3'b000, 64'd0, 3'b000, z, 0, 32, 3'b111, 32, 33, 34);
    add_row(0, 3'b111, 64'd0, 3'b000, z, 0, 29, 3'b111, 35, 36, 37);
    add_row(0, 3'b101, 64'd0, 3'b000, z, 0, 27, 3'b111, 36, 38, 39);
    add_row(0, 3'b000, 64'd1 << 32, 3'b000, z, 0, 28, 3'b111, 32, 36, 38);
    add_row(0, 3'b000, 64'd1, 3'b000, z, 0, 28, 3'b111, 32, 36, 38);
    awr = '0; awr[0] = 6'd32;
    add_row(0, 3'b111, 64'd1 << 1, 3'b001, awr, 1, 32, 3'b111, 1, 33, 34);
    add_row(1, 3'b111, 64'd1 << 40, 3'b000, z, 0, 32, 3'b111, 32, 33, 34);
    add_row(0, 3'b000, 64'd0, 3'b000, z, 0, 32, 3'b111, 32, 33, 34);
    for (int k = 1; k <= 10; k++) begin
      if (k < 10) add_row(0, 3'b111, 64'd0, 3'b000, z, 0, 32 - 3*k, 3'b111, 32 + 3*k, 33 + 3*k, 34 + 3*k);
      else        add_row(0, 3'b111, 64'd0, 3'b000, z, 0, 2, 3'b011, 62, 63, 0);
    end
    add_row(0, 3'b001, 64'd0, 3'b000, z, 0, 1, 3'b001, 63, 0, 0);
    add_row(0, 3'b111, 64'd0, 3'b000, z, 0, 0, 3'b000, 0, 0, 0);
    add_row(0, 3'b111, 64'd0, 3'b000, z, 0, 0, 3'b000, 0, 0, 0);

    foreach (vecs[r]) begin
      do_cycle(vecs[r].rst, vecs[r].req, vecs[r].fm, vecs[r].awe, vecs[r].awr, vecs[r].rec);
      cmp($sformatf("row%0d.count", r), 32'(free_count), 32'(vecs[r].exp_count));
      cmp($sformatf("row%0d.valid", r), 32'(alloc_valid), 32'(vecs[r].exp_valid));
      cmp($sformatf("row%0d.tags", r), 32'(alloc_tags), 32'(vecs[r].exp_tags));
    end

    // Free presented this cycle must not be visible until the next cycle.
    do_cycle(1, 3'b000, 64'd0, 3'b000, z, 0);
    do_cycle(0, 3'b001, 64'd0, 3'b000, z, 0);
    free_mask = 64'd1 << 32; alloc_req = '0; #1;
    cmp("nobypass.tag0", 32'(alloc_tags[0]), 32'd33);
    cmp("nobypass.count", 32'(free_count), 32'd31);
    do_cycle(0, 3'b000, 64'd1 << 32, 3'b000, z, 0);
    cmp("freed.tag0", 32'(alloc_tags[0]), 32'd32);
    cmp("freed.count", 32'(free_count), 32'd32);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      fm = '0;
      if ($urandom_range(0, 3) == 0) fm[$urandom_range(0, 63)] = 1'b1;
      if ($urandom_range(0, 7) == 0) fm[$urandom_range(0, 63)] = 1'b1;
      awe = '0; awr = '0;
      for (int w = 0; w < NL; w++) begin
        if ($urandom_range(0, 4) == 0) begin
          awe[w] = 1'b1;
          awr[w] = 6'($urandom_range(0, 63));
          fm[awr[w]] = 1'b0;
        end
      end
      do_cycle($urandom_range(0, 499) == 0, 3'($urandom_range(0, 7)), fm, awe, awr,
               $urandom_range(0, 39) == 0);
    end
    check_model("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
